// File: rtl/elastic_fifo_skp.sv
// Single-clock RX elastic buffer that holds occupancy near half depth by dropping or repeating SKP symbols.
// Optional per-event saturating statistics counters are enabled by defining ELASTIC_BUFFER_STATS_EN.
module elastic_fifo_skp #(
    parameter int                  DATA_WIDTH     = 10,
    parameter int                  BUFFER_DEPTH   = 16,
    parameter int                  ADDRESS_WIDTH  = 4,
    parameter logic [DATA_WIDTH-1:0] SKP_SYMBOL   = 10'h0F4,
    parameter int                  LOW_WATERMARK  = 4,
    parameter int                  HIGH_WATERMARK = 12
) (
    input  logic                    local_clock,
    input  logic                    local_reset,
    input  logic                    wr_valid,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    rd_en,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    data_valid,
    output logic [ADDRESS_WIDTH:0]  occupancy,
    output logic                    skp_added,
    output logic                    skp_removed,
    output logic                    overflow,
    output logic                    underflow,
    output logic                    dbg_run_o
`ifdef ELASTIC_BUFFER_STATS_EN
    ,
    output logic [15:0]             ins_count,
    output logic [15:0]             del_count,
    output logic [15:0]             ovf_count,
    output logic [15:0]             unf_count
`endif
);

    // Handshake: wr_valid pushes data_in unless the symbol is a droppable SKP or the buffer is
    // full without a same-cycle pop; rd_en in RUN yields data_out/data_valid one edge later.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam logic [ADDRESS_WIDTH:0] DEPTH_L = BUFFER_DEPTH[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] HALF_L  = DEPTH_L >> 1;
    localparam logic [ADDRESS_WIDTH:0] LOW_L   = LOW_WATERMARK[ADDRESS_WIDTH:0];
    localparam logic [ADDRESS_WIDTH:0] HIGH_L  = HIGH_WATERMARK[ADDRESS_WIDTH:0];

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDRESS_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0]    mem_q [BUFFER_DEPTH];
    logic [DATA_WIDTH-1:0]    data_out_q, data_out_d;
    logic                     data_valid_q, data_valid_d;
    logic                     skp_added_q, skp_added_d;
    logic                     skp_removed_q, skp_removed_d;
    logic                     overflow_q, overflow_d;
    logic                     underflow_q, underflow_d;

    logic [ADDRESS_WIDTH:0]   occ;
    logic                     empty;
    logic                     full;
    logic [DATA_WIDTH-1:0]    head;
    logic                     pop;
    logic                     wr_en;

    function automatic logic is_skp(input logic [DATA_WIDTH-1:0] sym);
        return (sym == SKP_SYMBOL) || (sym == ~SKP_SYMBOL);
    endfunction

    assign occ   = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (occ == DEPTH_L);
    assign head  = mem_q[rd_ptr_q[ADDRESS_WIDTH-1:0]];

    // Read side and FSM: FILL ignores rd_en until half depth is reached.
    always_comb begin
        state_d      = state_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        skp_added_d  = 1'b0;
        underflow_d  = 1'b0;
        pop          = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (occ >= HALF_L) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (rd_en) begin
                    if (empty) begin
                        underflow_d = 1'b1;
                        state_d     = ST_FILL;
                    end else if (is_skp(head) && (occ <= LOW_L)) begin
                        data_out_d   = head;
                        data_valid_d = 1'b1;
                        skp_added_d  = 1'b1;
                    end else begin
                        data_out_d   = head;
                        data_valid_d = 1'b1;
                        pop          = 1'b1;
                    end
                end
            end
            default: state_d = ST_FILL;
        endcase
        rd_ptr_d = rd_ptr_q + {{ADDRESS_WIDTH{1'b0}}, pop};
    end

    // Write side: a full buffer still accepts when the same cycle pops.
    always_comb begin
        wr_en         = 1'b0;
        skp_removed_d = 1'b0;
        overflow_d    = 1'b0;
        if (wr_valid) begin
            if (is_skp(data_in) && (occ >= HIGH_L)) begin
                skp_removed_d = 1'b1;
            end else if (full && !pop) begin
                overflow_d = 1'b1;
            end else begin
                wr_en = 1'b1;
            end
        end
        wr_ptr_d = wr_ptr_q + {{ADDRESS_WIDTH{1'b0}}, wr_en};
    end

    always_ff @(posedge local_clock or negedge local_reset) begin
        if (!local_reset) begin
            state_q       <= ST_FILL;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            data_out_q    <= '0;
            data_valid_q  <= 1'b0;
            skp_added_q   <= 1'b0;
            skp_removed_q <= 1'b0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            data_out_q    <= data_out_d;
            data_valid_q  <= data_valid_d;
            skp_added_q   <= skp_added_d;
            skp_removed_q <= skp_removed_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
        end
    end

    // Storage is deliberately left unreset.
    always_ff @(posedge local_clock) begin
        if (wr_en) begin
            mem_q[wr_ptr_q[ADDRESS_WIDTH-1:0]] <= data_in;
        end
    end

    assign data_out    = data_out_q;
    assign data_valid  = data_valid_q;
    assign occupancy   = occ;
    assign skp_added   = skp_added_q;
    assign skp_removed = skp_removed_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign dbg_run_o   = (state_q == ST_RUN);

`ifdef ELASTIC_BUFFER_STATS_EN
    logic [15:0] ins_cnt_q, del_cnt_q, ovf_cnt_q, unf_cnt_q;

    // Counters advance on the same edge that raises the matching pulse and stick at all-ones.
    always_ff @(posedge local_clock or negedge local_reset) begin
        if (!local_reset) begin
            ins_cnt_q <= '0;
            del_cnt_q <= '0;
            ovf_cnt_q <= '0;
            unf_cnt_q <= '0;
        end else begin
            if (skp_added_d && (ins_cnt_q != 16'hFFFF)) ins_cnt_q <= ins_cnt_q + 16'd1;
            if (skp_removed_d && (del_cnt_q != 16'hFFFF)) del_cnt_q <= del_cnt_q + 16'd1;
            if (overflow_d && (ovf_cnt_q != 16'hFFFF)) ovf_cnt_q <= ovf_cnt_q + 16'd1;
            if (underflow_d && (unf_cnt_q != 16'hFFFF)) unf_cnt_q <= unf_cnt_q + 16'd1;
        end
    end

    assign ins_count = ins_cnt_q;
    assign del_count = del_cnt_q;
    assign ovf_count = ovf_cnt_q;
    assign unf_count = unf_cnt_q;
`endif

endmodule

// File: tb/tb_elastic_fifo_skp.sv
// Directed bench for elastic_fifo_skp: fill/drain, SKP drop/repeat, full, pointer wrap and mid-stream reset.
module tb_elastic_fifo_skp;

    logic        clk;
    logic        local_reset;
    logic        wr_valid;
    logic [9:0]  data_in;
    logic        rd_en;
    logic [9:0]  data_out;
    logic        data_valid;
    logic [4:0]  occupancy;
    logic        skp_added;
    logic        skp_removed;
    logic        overflow;
    logic        underflow;
    logic        dbg_run;
`ifdef ELASTIC_BUFFER_STATS_EN
    logic [15:0] ins_count, del_count, ovf_count, unf_count;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;

    elastic_fifo_skp dut (
        .local_clock (clk),
        .local_reset (local_reset),
        .wr_valid    (wr_valid),
        .data_in     (data_in),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .occupancy   (occupancy),
        .skp_added   (skp_added),
        .skp_removed (skp_removed),
        .overflow    (overflow),
        .underflow   (underflow),
        .dbg_run_o   (dbg_run)
`ifdef ELASTIC_BUFFER_STATS_EN
        ,
        .ins_count   (ins_count),
        .del_count   (del_count),
        .ovf_count   (ovf_count),
        .unf_count   (unf_count)
`endif
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    // Driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        wr_valid = 1'b1;
        data_in  = d;
        tick();
        wr_valid = 1'b0;
    endtask

    task automatic do_reset();
        local_reset = 1'b0;
        wr_valid    = 1'b0;
        rd_en       = 1'b0;
        data_in     = '0;
        tick();
        @(negedge clk);
        local_reset = 1'b1;
    endtask

    // Scoreboard compare
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset values
        do_reset();
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_occupancy", 32'(occupancy), 32'h0);
        check("rst_pulses", {28'h0, skp_added, skp_removed, overflow, underflow}, 32'h0);
        check("rst_state", 32'(dbg_run), 32'h0);

        // Fill 8 with rd_en high, drain, then underflow back to FILL
        rd_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            push(10'(i));
            exp_q.push_back(10'(i));
        end
        check("t1_occ8", 32'(occupancy), 32'd8);
        check("t1_no_valid_fill", 32'(data_valid), 32'h0);
        tick();
        check("t1_run", 32'(dbg_run), 32'h1);
        check("t1_no_valid_yet", 32'(data_valid), 32'h0);
        for (int i = 0; i < 8; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check("t1_valid", 32'(data_valid), 32'h1);
            check("t1_data", 32'(data_out), 32'(exp_v));
            check("t1_occ", 32'(occupancy), 32'(7 - i));
        end
        tick();
        check("t1_underflow", 32'(underflow), 32'h1);
        check("t1_uf_valid", 32'(data_valid), 32'h0);
        check("t1_back_fill", 32'(dbg_run), 32'h0);
        tick();
        check("t1_underflow_once", 32'(underflow), 32'h0);
        rd_en = 1'b0;

        // SKP deletion at high watermark; RD+ SKP accepted below it
        for (int i = 1; i <= 11; i++) push(10'h100 + 10'(i));
        check("t2_occ11", 32'(occupancy), 32'd11);
        push(10'h30B);
        check("t2_30b_accept_occ", 32'(occupancy), 32'd12);
        check("t2_30b_no_remove", 32'(skp_removed), 32'h0);
        push(10'h0F4);
        check("t2_0f4_removed", 32'(skp_removed), 32'h1);
        check("t2_0f4_occ", 32'(occupancy), 32'd12);
        push(10'h30B);
        check("t2_30b_removed", 32'(skp_removed), 32'h1);
        check("t2_30b_occ", 32'(occupancy), 32'd12);
        tick();
        check("t2_pulse_clear", 32'(skp_removed), 32'h0);

        // SKP repetition at low watermark
        do_reset();
        push(10'h0A1); push(10'h0A2); push(10'h0A3); push(10'h0A4);
        push(10'h0F4);
        push(10'h0B1); push(10'h0B2); push(10'h0B3);
        tick();
        check("t3_run", 32'(dbg_run), 32'h1);
        rd_en = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("t3_pre_data", 32'(data_out), 32'h0A0 + 32'(i));
            check("t3_pre_no_add", 32'(skp_added), 32'h0);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t3_skp_data", 32'(data_out), 32'h0F4);
            check("t3_skp_valid", 32'(data_valid), 32'h1);
            check("t3_skp_added", 32'(skp_added), 32'h1);
            check("t3_skp_occ", 32'(occupancy), 32'd4);
        end
        rd_en = 1'b0;
        tick();
        check("t3_idle_add", 32'(skp_added), 32'h0);
        check("t3_idle_valid", 32'(data_valid), 32'h0);
        check("t3_idle_hold", 32'(data_out), 32'h0F4);
`ifdef ELASTIC_BUFFER_STATS_EN
        check("t3_ins_count", 32'(ins_count), 32'd3);
`endif

        // Full buffer: overflow without pop, accepted with pop
        do_reset();
        for (int i = 0; i < 16; i++) push(10'h200 + 10'(i));
        check("t4_occ16", 32'(occupancy), 32'd16);
        push(10'h155);
        check("t4_overflow", 32'(overflow), 32'h1);
        check("t4_ovf_occ", 32'(occupancy), 32'd16);
        tick();
        check("t4_ovf_clear", 32'(overflow), 32'h0);
        rd_en = 1'b1;
        push(10'h155);
        check("t4_pp_no_ovf", 32'(overflow), 32'h0);
        check("t4_pp_occ", 32'(occupancy), 32'd16);
        check("t4_pp_data", 32'(data_out), 32'h200);
        for (int i = 1; i < 16; i++) exp_q.push_back(10'h200 + 10'(i));
        exp_q.push_back(10'h155);
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            check("t4_drain", 32'(data_out), 32'(exp_v));
        end
        check("t4_empty", 32'(occupancy), 32'd0);
        rd_en = 1'b0;

        // Pointer wrap under continuous write+read
        do_reset();
        for (int i = 0; i < 8; i++) begin
            push(10'h040 + 10'(i));
            exp_q.push_back(10'h040 + 10'(i));
        end
        tick();
        rd_en = 1'b1;
        for (int k = 0; k < 100; k++) begin
            wr_valid = 1'b1;
            data_in  = 10'h048 + 10'(k);
            exp_q.push_back(data_in);
            tick();
            exp_v = exp_q.pop_front();
            check("t5_wrap_data", 32'(data_out), 32'(exp_v));
            check("t5_wrap_occ", 32'(occupancy), 32'd8);
        end
        wr_valid = 1'b0;
        rd_en    = 1'b0;
        push(10'h0AC);
        push(10'h0AD);
        check("t6_occ10", 32'(occupancy), 32'd10);
        check("t6_hold_data", 32'(data_out), 32'h0A3);

        // Mid-stream asynchronous reset with a write pending
        wr_valid = 1'b1;
        data_in  = 10'h0AE;
        rd_en    = 1'b1;
        #2;
        local_reset = 1'b0;
        #1;
        check("t6_rst_data", 32'(data_out), 32'h0);
        check("t6_rst_occ", 32'(occupancy), 32'h0);
        check("t6_rst_state", 32'(dbg_run), 32'h0);
        check("t6_rst_valid", 32'(data_valid), 32'h0);
        @(negedge clk);
        wr_valid    = 1'b0;
        local_reset = 1'b1;
        tick();
        check("t6_post_occ", 32'(occupancy), 32'h0);
        check("t6_post_no_valid", 32'(data_valid), 32'h0);
        for (int i = 0; i < 8; i++) push(10'h0C0 + 10'(i));
        check("t6_fill_no_valid", 32'(data_valid), 32'h0);
        tick();
        check("t6_run_no_valid", 32'(data_valid), 32'h0);
        tick();
        check("t6_valid", 32'(data_valid), 32'h1);
        check("t6_first", 32'(data_out), 32'h0C0);
        rd_en = 1'b0;

        // Final report
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
